// File: rtl/l2_bank_adapter.sv
// Crossbar slave port to single-port L2 SRAM bank without byte enables.
// Partial writes are done as a two-cycle read-modify-write; responses always follow the grant by one cycle.
module l2_bank_adapter #(
    parameter  int unsigned CFI_DATA_WIDTH  = 32,
    parameter  int unsigned NR_BANKS        = 4,
    parameter  int unsigned BANK_WORDS      = 16384,
    localparam int unsigned BANK_ADDR_WIDTH = $clog2(BANK_WORDS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic [31:0]                add_i,
    input  logic                       wen_i,
    input  logic [3:0]                 be_i,
    input  logic [CFI_DATA_WIDTH-1:0]  wdata_i,
    output logic                       gnt_o,
    output logic [CFI_DATA_WIDTH-1:0]  r_rdata_o,
    output logic                       r_opc_o,
    output logic                       r_valid_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [BANK_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [CFI_DATA_WIDTH-1:0]  mem_wdata_o,
    input  logic [CFI_DATA_WIDTH-1:0]  mem_rdata_i,
    output logic                       dbg_state_o
);

    localparam int unsigned PORT_SEL_WIDTH = $clog2(NR_BANKS);
    localparam int unsigned WIDX_WIDTH     = 30 - PORT_SEL_WIDTH;
    localparam logic [31:0] BANK_WORDS_W   = 32'(BANK_WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    state_e                     state;
    logic [BANK_ADDR_WIDTH-1:0] hold_addr;
    logic [3:0]                 hold_be;
    logic [31:0]                hold_wdata;
    logic                       rsp_valid;
    logic                       rsp_opc;
    logic                       rsp_is_read;

    logic [WIDX_WIDTH-1:0]      widx;
    logic                       out_of_range;
    logic                       accept;
    logic                       full_write;
    logic [CFI_DATA_WIDTH-1:0]  merged;
    logic                       unused_addr_bits;

    // Byte-in-word and bank-select bits are consumed by the crossbar, not by this port.
    assign unused_addr_bits = ^add_i[1+PORT_SEL_WIDTH:0];

    assign widx         = add_i[31:2+PORT_SEL_WIDTH];
    assign out_of_range = 32'(widx) >= BANK_WORDS_W;
    assign accept       = rst_ni && req_i && (state == IDLE);
    assign full_write   = !wen_i && (be_i == 4'hF);
    assign dbg_state_o  = (state == MERGE);

    // Tag bits and unselected bytes come from the word read in the grant cycle.
    always_comb begin
        merged = mem_rdata_i;
        for (int b = 0; b < 4; b++) begin
            if (hold_be[b]) merged[8*b +: 8] = hold_wdata[8*b +: 8];
        end
    end

    always_comb begin
        gnt_o       = accept;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (rst_ni && state == MERGE) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = hold_addr;
            mem_wdata_o = merged;
        end else if (accept && !out_of_range) begin
            mem_req_o  = 1'b1;
            mem_addr_o = widx[BANK_ADDR_WIDTH-1:0];
            if (full_write) begin
                mem_we_o    = 1'b1;
                mem_wdata_o = wdata_i;
            end
        end
    end

    assign r_valid_o = rsp_valid;
    assign r_opc_o   = rsp_opc;
    assign r_rdata_o = (rsp_is_read && !rsp_opc) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            hold_addr   <= '0;
            hold_be     <= '0;
            hold_wdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_opc     <= 1'b0;
            rsp_is_read <= 1'b0;
        end else begin
            rsp_valid   <= accept;
            rsp_opc     <= accept && out_of_range;
            rsp_is_read <= accept && wen_i && !out_of_range;
            case (state)
                IDLE: begin
                    if (accept && !out_of_range && !wen_i && !full_write) begin
                        state      <= MERGE;
                        hold_addr  <= widx[BANK_ADDR_WIDTH-1:0];
                        hold_be    <= be_i;
                        hold_wdata <= wdata_i[31:0];
                    end
                end
                MERGE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_bank_adapter.sv
// Directed bench for l2_bank_adapter: SRAM macro model, word-level reference memory and a per-cycle compare process.
module tb_l2_bank_adapter;

    localparam int W  = 33;
    localparam int NB = 4;
    localparam int BW = 1000;
    localparam int AW = 10;

    logic          clk     = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          req_i   = 1'b0;
    logic [31:0]   add_i   = '0;
    logic          wen_i   = 1'b1;
    logic [3:0]    be_i    = '0;
    logic [W-1:0]  wdata_i = '0;
    logic          gnt_o;
    logic [W-1:0]  r_rdata_o;
    logic          r_opc_o;
    logic          r_valid_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_wdata_o;
    logic [W-1:0]  mem_rdata_i = '0;
    logic          dbg_state;

    l2_bank_adapter #(
        .CFI_DATA_WIDTH(W),
        .NR_BANKS      (NB),
        .BANK_WORDS    (BW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .add_i      (add_i),
        .wen_i      (wen_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .r_rdata_o  (r_rdata_o),
        .r_opc_o    (r_opc_o),
        .r_valid_o  (r_valid_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // SRAM macro: registered read data, no byte enables.
    logic [W-1:0] sram    [0:1023];
    logic [W-1:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i      <= sram[mem_addr_o];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] merge_word(input logic [W-1:0] old, input logic [3:0] be,
                                                input logic [31:0] wd);
        logic [W-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Reference model state: pending RMW and the response due next cycle.
    bit           busy = 0;
    logic [AW-1:0] pend_idx = '0;
    logic [3:0]   pend_be = '0;
    logic [31:0]  pend_wd = '0;
    bit           exp_v = 0;
    bit           exp_opc = 0;
    logic [W-1:0] exp_rd = '0;
    int           stall_cnt = 0;
    int           valid_run = 0;
    int           valid_run_max = 0;

    always @(negedge clk) begin
        logic [W-1:0]  mw;
        logic [AW-1:0] idx;
        bit            nv;
        bit            nopc;
        logic [W-1:0]  nrd;
        if (!rst_ni) begin
            check("rst_gnt",     64'(gnt_o),     64'(0));
            check("rst_valid",   64'(r_valid_o), 64'(0));
            check("rst_opc",     64'(r_opc_o),   64'(0));
            check("rst_rdata",   64'(r_rdata_o), 64'(0));
            check("rst_mem_req", 64'(mem_req_o), 64'(0));
            check("rst_mem_we",  64'(mem_we_o),  64'(0));
            busy = 0; exp_v = 0; exp_opc = 0; exp_rd = '0; valid_run = 0;
        end else begin
            check("r_valid", 64'(r_valid_o), 64'(exp_v));
            check("r_opc",   64'(r_opc_o),   64'(exp_opc));
            check("r_rdata", 64'(r_rdata_o), 64'(exp_rd));
            valid_run = r_valid_o ? valid_run + 1 : 0;
            if (valid_run > valid_run_max) valid_run_max = valid_run;
            if (req_i && !gnt_o) stall_cnt++;
            nv = 0; nopc = 0; nrd = '0;
            if (busy) begin
                mw = merge_word(ref_mem[pend_idx], pend_be, pend_wd);
                check("merge_gnt",   64'(gnt_o),       64'(0));
                check("merge_req",   64'(mem_req_o),   64'(1));
                check("merge_we",    64'(mem_we_o),    64'(1));
                check("merge_addr",  64'(mem_addr_o),  64'(pend_idx));
                check("merge_wdata", 64'(mem_wdata_o), 64'(mw));
                ref_mem[pend_idx] = mw;
                busy = 0;
            end else if (req_i) begin
                idx = add_i[AW+3:4];
                nv  = 1;
                check("gnt", 64'(gnt_o), 64'(1));
                if (add_i[31:4] >= 28'(BW)) begin
                    check("oor_mem_req", 64'(mem_req_o), 64'(0));
                    check("oor_mem_we",  64'(mem_we_o),  64'(0));
                    nopc = 1;
                end else if (wen_i) begin
                    check("rd_mem_req",  64'(mem_req_o),  64'(1));
                    check("rd_mem_we",   64'(mem_we_o),   64'(0));
                    check("rd_mem_addr", 64'(mem_addr_o), 64'(idx));
                    nrd = ref_mem[idx];
                end else if (be_i == 4'hF) begin
                    check("wr_mem_req",   64'(mem_req_o),   64'(1));
                    check("wr_mem_we",    64'(mem_we_o),    64'(1));
                    check("wr_mem_addr",  64'(mem_addr_o),  64'(idx));
                    check("wr_mem_wdata", 64'(mem_wdata_o), 64'(wdata_i));
                    ref_mem[idx] = wdata_i;
                end else begin
                    check("pw_mem_req",  64'(mem_req_o),  64'(1));
                    check("pw_mem_we",   64'(mem_we_o),   64'(0));
                    check("pw_mem_addr", 64'(mem_addr_o), 64'(idx));
                    busy = 1; pend_idx = idx; pend_be = be_i; pend_wd = wdata_i[31:0];
                end
            end else begin
                check("idle_gnt",       64'(gnt_o),       64'(0));
                check("idle_mem_req",   64'(mem_req_o),   64'(0));
                check("idle_mem_we",    64'(mem_we_o),    64'(0));
                check("idle_mem_addr",  64'(mem_addr_o),  64'(0));
                check("idle_mem_wdata", 64'(mem_wdata_o), 64'(0));
            end
            exp_v = nv; exp_opc = nopc; exp_rd = nrd;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the grant edge.
    task automatic issue(input logic wen, input logic [31:0] add, input logic [3:0] be,
                         input logic [W-1:0] wd);
        int n;
        n = 0;
        req_i = 1'b1; wen_i = wen; add_i = add; be_i = be; wdata_i = wd;
        @(negedge clk);
        while (!gnt_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", 64'(gnt_o), 64'(1));
        @(posedge clk); #1;
        req_i = 1'b0; wen_i = 1'b1; add_i = '0; be_i = '0; wdata_i = '0;
    endtask

    task automatic get_rsp(output logic v, output logic opc, output logic [W-1:0] d);
        @(negedge clk);
        v = r_valid_o; opc = r_opc_o; d = r_rdata_o;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] v;
        logic         rv;
        logic         ropc;
        logic [W-1:0] rd;
        for (int i = 0; i < 1024; i++) begin
            v[31:0] = $urandom();
            v[32]   = 1'($urandom_range(0, 1));
            sram[i] = v;
            ref_mem[i] = v;
        end

        // Reset held with a request pending
        req_i = 1'b1; wen_i = 1'b1; add_i = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_gnt",     64'(gnt_o),     64'(0));
        check("lit_rst_valid",   64'(r_valid_o), 64'(0));
        check("lit_rst_mem_req", 64'(mem_req_o), 64'(0));
        req_i = 1'b0;
        rst_ni = 1'b1;
        idle(1);

        // Full write then read next cycle
        issue(1'b0, 32'h10, 4'hF, 33'h1_DEADBEEF);
        issue(1'b1, 32'h10, 4'h0, '0);
        get_rsp(rv, ropc, rd);
        check("lit_full_rd_valid", 64'(rv),   64'(1));
        check("lit_full_rd_opc",   64'(ropc), 64'(0));
        check("lit_full_rd_data",  64'(rd),   64'h1_DEADBEEF);

        // Partial write, read queued behind it
        issue(1'b0, 32'h10, 4'b0101, 33'h0_11223344);
        issue(1'b1, 32'h10, 4'h0, '0);
        get_rsp(rv, ropc, rd);
        check("lit_pw_rd_data", 64'(rd), 64'h1_DE22BE44);

        // Top-byte partial with opposite tag in wdata, and an empty byte mask
        issue(1'b0, 32'h20, 4'hF, 33'h0_12345678);
        issue(1'b0, 32'h20, 4'b1000, 33'h1_AB000000);
        issue(1'b0, 32'h30, 4'h0, 33'h1_FFFFFFFF);
        issue(1'b1, 32'h20, 4'h0, '0);
        get_rsp(rv, ropc, rd);
        check("lit_pw_top_data", 64'(rd), 64'h0_AB345678);

        // Out-of-range accesses
        issue(1'b1, 32'(BW) << 4, 4'h0, '0);
        get_rsp(rv, ropc, rd);
        check("lit_oor_valid", 64'(rv),   64'(1));
        check("lit_oor_opc",   64'(ropc), 64'(1));
        check("lit_oor_data",  64'(rd),   64'(0));
        issue(1'b0, 32'hFFFF_FFF0, 4'h3, 33'h1_55555555);
        issue(1'b0, (32'(BW) << 4) + 32'h4, 4'hF, 33'h1_00000001);
        issue(1'b1, 32'h3F80, 4'h0, '0);
        idle(2);

        // Eight back-to-back reads
        valid_run_max = 0;
        for (int i = 1; i <= 8; i++) issue(1'b1, 32'(i) << 4, 4'h0, '0);
        idle(3);
        check("lit_stream_valid_run", 64'(valid_run_max), 64'(8));

        // Partial write mid-stream stalls exactly once
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'(i + 40) << 4, 4'h0, '0);
        issue(1'b0, 32'h2A0, 4'b0110, 33'h0_A5C3E1F0);
        for (int i = 0; i < 3; i++) issue(1'b1, 32'(i + 42) << 4, 4'h0, '0);
        idle(3);
        check("lit_stream_stalls", 64'(stall_cnt), 64'(1));

        // Reset during MERGE aborts the write
        issue(1'b0, 32'h50, 4'hF, 33'h0_CAFEF00D);
        issue(1'b0, 32'h50, 4'b0011, 33'h0_00001111);
        rst_ni = 1'b0;
        @(negedge clk);
        check("lit_rmw_rst_mem_req", 64'(mem_req_o), 64'(0));
        check("lit_rmw_rst_state",   64'(dbg_state), 64'(0));
        idle(2);
        rst_ni = 1'b1;
        idle(1);
        issue(1'b1, 32'h50, 4'h0, '0);
        get_rsp(rv, ropc, rd);
        check("lit_rmw_rst_data", 64'(rd), 64'h0_CAFEF00D);

        // Random-tag partials on fresh words, then compare the whole array
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 32'(100 + i) << 4, 4'(i + 1), {1'($urandom_range(0, 1)), 32'($urandom())});
            issue(1'b1, 32'(100 + i) << 4, 4'h0, '0);
        end
        idle(3);
        for (int i = 0; i < 1024; i++) check($sformatf("sram_word_%0d", i), 64'(sram[i]), 64'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_bank_adapter.md
# l2_bank_adapter

Terminates one interleaved-crossbar slave port and drives one single-port L2 SRAM bank macro that has no byte-enable support. Reads, full-word writes and out-of-range accesses complete in a single SRAM cycle. Partial writes use a two-cycle read-modify-write (RMW) sequence. The response always returns exactly one cycle after grant, which matches the crossbar's fixed response latency of 1 with write responses enabled.

## Interface
Parameters:
- CFI_DATA_WIDTH, 32: data width; bits [31:0] are byte-addressable, bits [CFI_DATA_WIDTH-1:32] are CFI tag bits.
- NR_BANKS, 4: number of interleaved banks (power of two); PORT_SEL_WIDTH = $clog2(NR_BANKS).
- BANK_WORDS, 16384: words in this bank; need not be a power of two.
- BANK_ADDR_WIDTH = $clog2(BANK_WORDS): derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  TCDM request.
- add_i  in  32  byte address.
- wen_i  in  1  1 = read, 0 = write.
- be_i  in  4  byte enables for bits [31:0].
- wdata_i  in  CFI_DATA_WIDTH  write data.
- gnt_o  out  1  grant.
- r_rdata_o  out  CFI_DATA_WIDTH  response data.
- r_opc_o  out  1  1 = error.
- r_valid_o  out  1  response valid.
- mem_req_o  out  1  SRAM chip enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  BANK_ADDR_WIDTH  SRAM word address.
- mem_wdata_o  out  CFI_DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  CFI_DATA_WIDTH  SRAM read data, valid the cycle after a read request.

## Operation
- Word index: widx = add_i[31 : 2+PORT_SEL_WIDTH], zero-extended.
- Out of range: widx ≥ BANK_WORDS. The request is granted with no SRAM access, and the response has r_opc_o=1 and r_rdata_o='0.
- FSM states: IDLE, MERGE.
- IDLE: gnt_o = req_i (combinational).
  - Read: mem_req_o=1, mem_we_o=0.
  - Full write (be_i=4'hF): mem_req_o=1, mem_we_o=1, mem_wdata_o=wdata_i. Tag bits are written.
  - Partial write (be_i≠4'hF, including 4'h0): issue an SRAM read, then latch address, be_i and wdata_i. Go to MERGE.
- MERGE: gnt_o=0, mem_req_o=1, mem_we_o=1, same address.
  - Merged data: byte b of [31:0] = be[b] ? wdata byte : mem_rdata_i byte.
  - Tag bits = mem_rdata_i tag bits (preserved).
  - Return to IDLE.
- Response registers: rsp_valid, rsp_opc, rsp_is_read.
  - r_valid_o = rsp_valid.
  - r_opc_o = rsp_opc.
  - r_rdata_o = (rsp_is_read && !rsp_opc) ? mem_rdata_i : '0.
- Writes and errors return r_rdata_o='0.
- When no request is active, mem_* outputs are 0 / '0.

## Timing
- Reset values: state=IDLE, r_valid_o=0, r_opc_o=0, r_rdata_o='0, gnt_o=0 (since req_i is 0), mem_req_o=0, mem_we_o=0.
- Every granted request: r_valid_o=1 in grant cycle +1, for exactly one cycle. This holds for partial writes too: the ack is issued during MERGE, before the SRAM write edge.
- Read data: mem_rdata_i in cycle N+1 for a read issued in cycle N, passed through combinationally.
- Throughput: one request per cycle for reads, full writes and errors. A partial write occupies 2 cycles, so the next grant is possible at earliest in cycle N+2.
- A read granted in cycle N+2 after a partial write at address A returns the merged value.
- Back-to-back reads: r_valid_o stays high continuously.
- req_i while in MERGE: held off by gnt_o=0. The master keeps req_i and its payload stable until granted.
- Reset asserted during MERGE: the RMW is aborted and the SRAM write is not issued. All outputs take their reset values asynchronously.

## Test plan
- Reset: hold rst_ni=0 with req_i=1 -> gnt_o=0, r_valid_o=0, mem_req_o=0.
- Full write then read (NR_BANKS=4, add=0x10, data 0x1_DEADBEEF with CFI_DATA_WIDTH=33): write ack r_valid=1 with rdata=0. Read issued next cycle -> rdata=0x1_DEADBEEF, opc=0, valid 1 cycle after grant.
- Partial write: word holds 0x1_DEADBEEF; write be=4'b0101, wdata=0x0_11223344 -> gnt=1 then 0, one SRAM read then one SRAM write. Read back -> 0x1_DE22BE44, and the tag bit is preserved.
- Out of range: BANK_WORDS=1000, add=(1000<<4) -> gnt=1, mem_req_o=0, next cycle r_valid=1, r_opc=1, rdata=0.
- Streaming: 8 back-to-back reads -> 8 consecutive r_valid cycles with correct data. A partial write inserted mid-stream -> exactly one cycle with gnt=0.
- Reset during MERGE: the stored word is unchanged, and after reset the FSM is in IDLE and accepts a new request.
